// File: rtl/dir_cmd_queue.sv
// rtl/dir_cmd_queue.sv - direction command queue with edge detect, legality filter and heading tracking
module dir_cmd_queue #(
    parameter int          DEPTH     = 4,
    parameter int          PTR_W     = 2,
    parameter logic [1:0]  RESET_DIR = 2'b01
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             btn_up,
    input  logic             btn_right,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             cmd_pop,
    output logic             cmd_valid,
    output logic [1:0]       cmd_dir,
    output logic [1:0]       heading,
    output logic [PTR_W:0]   count,
    output logic             overflow
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [1:0]       mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   cnt;
    logic [1:0]       heading_r;
    logic             overflow_r;

    // bit order {left, down, right, up}
    logic [3:0] btn_q;
    logic [3:0] btn_prev;
    logic [3:0] press;

    logic       cand_valid;
    logic [1:0] cand;
    logic [1:0] ref_dir;
    logic       legal;
    logic       full;
    logic       pop_fire;
    logic       push_fire;

    assign press = btn_q & ~btn_prev;

    always_comb begin
        cand_valid = 1'b1;
        cand       = 2'b00;
        if (press[0])      cand = 2'b00;
        else if (press[1]) cand = 2'b01;
        else if (press[2]) cand = 2'b10;
        else if (press[3]) cand = 2'b11;
        else               cand_valid = 1'b0;
    end

    // The entry popped this cycle still serves as reference for a same-cycle push.
    assign ref_dir   = (cnt != '0) ? mem[tail - PTR_W'(1)] : heading_r;
    assign legal     = cand_valid && (cand != ref_dir) && (cand != (ref_dir ^ 2'b10));
    assign full      = (cnt == FULL_COUNT);
    assign pop_fire  = cmd_pop && (cnt != '0);
    assign push_fire = legal && (!full || pop_fire);

    always_ff @(posedge clock) begin
        if (push_fire) begin
            mem[tail] <= cand;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            head       <= '0;
            tail       <= '0;
            cnt        <= '0;
            heading_r  <= RESET_DIR;
            overflow_r <= 1'b0;
            btn_q      <= 4'b1111;
            btn_prev   <= 4'b1111;
        end else begin
            btn_q      <= {btn_left, btn_down, btn_right, btn_up};
            btn_prev   <= btn_q;
            overflow_r <= legal && full && !pop_fire;
            if (push_fire) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop_fire) begin
                head      <= head + PTR_W'(1);
                heading_r <= mem[head];
            end
            if (push_fire && !pop_fire) begin
                cnt <= cnt + (PTR_W+1)'(1);
            end else if (pop_fire && !push_fire) begin
                cnt <= cnt - (PTR_W+1)'(1);
            end
        end
    end

    assign cmd_valid = (cnt != '0);
    assign cmd_dir   = mem[head];
    assign heading   = heading_r;
    assign count     = cnt;
    assign overflow  = overflow_r;

endmodule
